// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-bus arbiter: sequencer states and bus-owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store, one transaction
// at a time, with round-robin tie-break, pipeline stall output and a response timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_wstrb,
  output logic              d_valid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              err,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_owner;
  logic                r_last;
  logic [7:0]          r_cnt;
  logic                r_bus_we;
  logic [XLEN-1:0]     r_bus_addr;
  logic [XLEN-1:0]     r_bus_wdata;
  logic [XLEN/8-1:0]   r_bus_wstrb;

  logic                w_pick_data;
  logic                w_launch;
  logic                w_resp;
  logic                w_tmo;
  logic                w_done;

  // On a tie the requester that did not complete last wins.
  assign w_pick_data = d_req & (~if_req | (r_last == OWNER_FETCH));
  assign w_launch    = (r_state == ST_IDLE) & (if_req | d_req);
  assign w_resp      = (r_state == ST_WAIT) & bus_rvalid & ~reset;
  assign w_tmo       = (r_state == ST_WAIT) & ~bus_rvalid & (r_cnt == TO_LIMIT) & ~reset;
  assign w_done      = w_resp | w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (if_req | d_req)                  w_state_nxt = ST_REQ;
      ST_REQ:  if (bus_gnt)                         w_state_nxt = ST_WAIT;
      ST_WAIT: if (bus_rvalid || r_cnt == TO_LIMIT) w_state_nxt = ST_IDLE;
      default:                                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_FETCH;
      r_last      <= OWNER_FETCH;
      r_cnt       <= 8'd0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_owner <= w_pick_data;
        if (w_pick_data) begin
          r_bus_we    <= d_we;
          r_bus_addr  <= d_addr;
          r_bus_wdata <= d_wdata;
          r_bus_wstrb <= d_wstrb;
        end else begin
          r_bus_we    <= 1'b0;
          r_bus_addr  <= if_addr;
          r_bus_wdata <= '0;
          r_bus_wstrb <= '0;
        end
      end
      // Entry cycle of WAIT sees 0; timeout fires when the count equals TIMEOUT.
      if (r_state == ST_REQ && bus_gnt) r_cnt <= 8'd0;
      else if (r_state == ST_WAIT)      r_cnt <= r_cnt + 8'd1;
      if (w_resp) r_last <= r_owner;
    end
  end

  assign if_valid  = w_done & (r_owner == OWNER_FETCH);
  assign d_valid   = w_done & (r_owner == OWNER_DATA);
  assign err       = w_tmo;
  assign if_rdata  = (w_resp && r_owner == OWNER_FETCH) ? bus_rdata[31:0] : 32'd0;
  assign d_rdata   = (w_resp && r_owner == OWNER_DATA)  ? bus_rdata       : '0;
  assign stall     = (if_req & ~if_valid) | (d_req & ~d_valid);

  assign bus_req   = (r_state == ST_REQ) & ~reset;
  assign bus_we    = r_bus_we & ~reset;
  assign bus_addr  = reset ? '0 : r_bus_addr;
  assign bus_wdata = reset ? '0 : r_bus_wdata;
  assign bus_wstrb = reset ? '0 : r_bus_wstrb;

endmodule
